// File: rtl/multi_client_sm_arbiter_pkg.sv
// Shared types and constants for the multi-client state-machine arbiter.
// The target is handed to one requester at a time and walks the arb_state_t sequence below.
package multi_client_arb_pkg;

    localparam int MAX_CLIENTS = 16;

    typedef enum logic [2:0] {
        IDLE,
        GIVE_START,
        WAIT_FINISH,
        REGISTER_DATA,
        GIVE_FINISH
    } arb_state_t;

    // Watchdog counter width; stays at one bit when the watchdog is disabled or trivially short.
    function automatic int wd_width(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/multi_client_sm_arbiter_if.sv
// Client/target bundle for the arbiter.
// master is the arbiter's view of the bundle; slave is the view of the clients and the target.
interface multi_client_sm_arbiter_if
    import multi_client_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ARG_W       = 32,
    parameter int DATA_W      = 8,
    parameter int GID_W       = $clog2(NUM_CLIENTS)
);
    logic [NUM_CLIENTS-1:0]        start_request;
    logic [NUM_CLIENTS-1:0]        reset_start_request;
    logic [NUM_CLIENTS-1:0]        finish;
    logic [NUM_CLIENTS-1:0]        timeout_error;
    logic [NUM_CLIENTS*ARG_W-1:0]  input_arguments;
    logic [ARG_W-1:0]              output_arguments;
    logic                          start_target_state_machine;
    logic                          target_state_machine_finished;
    logic [DATA_W-1:0]             in_received_data;
    logic [NUM_CLIENTS*DATA_W-1:0] received_data;
    logic [GID_W-1:0]              grant_id;
    logic                          busy;

    modport master (
        input  start_request, input_arguments, target_state_machine_finished, in_received_data,
        output reset_start_request, finish, timeout_error, output_arguments,
        output start_target_state_machine, received_data, grant_id, busy
    );

    modport slave (
        output start_request, input_arguments, target_state_machine_finished, in_received_data,
        input  reset_start_request, finish, timeout_error, output_arguments,
        input  start_target_state_machine, received_data, grant_id, busy
    );

endinterface

// File: rtl/multi_client_sm_arbiter_picker.sv
// Round-robin winner selection: first requester found scanning upward from last_grant+1, wrapping.
// The request vector is doubled and shifted so the scan becomes a plain lowest-bit priority encode.
module rr_priority_picker #(
    parameter int NUM_CLIENTS = 4,
    parameter int GID_W       = $clog2(NUM_CLIENTS)
) (
    input  logic [NUM_CLIENTS-1:0] request,
    input  logic [GID_W-1:0]       last_grant,
    output logic                   valid,
    output logic [GID_W-1:0]       winner
);
    logic [2*NUM_CLIENTS-1:0] doubled;
    logic [NUM_CLIENTS-1:0]   rotated;
    int                       start_pos;
    int                       offset;
    int                       sum;

    always_comb begin
        start_pos = (int'(last_grant) >= NUM_CLIENTS - 1) ? 0 : int'(last_grant) + 1;
        doubled   = {request, request};
        rotated   = NUM_CLIENTS'(doubled >> start_pos);
        offset    = 0;
        for (int k = NUM_CLIENTS - 1; k >= 0; k--) begin
            if (rotated[k]) begin
                offset = k;
            end
        end
        sum = start_pos + offset;
        if (sum >= NUM_CLIENTS) begin
            sum = sum - NUM_CLIENTS;
        end
        valid  = |request;
        winner = GID_W'(sum);
    end

endmodule

// File: rtl/multi_client_sm_arbiter.sv
// Shares one target state machine among NUM_CLIENTS requesters with round-robin grants,
// per-client result capture and an optional WAIT_FINISH watchdog.
module multi_client_sm_arbiter
    import multi_client_arb_pkg::*;
#(
    parameter int NUM_CLIENTS = 4,
    parameter int ARG_W       = 32,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 0,
    parameter int GID_W       = $clog2(NUM_CLIENTS)
) (
    input logic                       sm_clk,
    input logic                       reset,
    multi_client_sm_arbiter_if.master bus
);
    localparam int               WD_W        = wd_width(TIMEOUT_CYC);
    localparam logic [WD_W-1:0]  WD_LIMIT    = (TIMEOUT_CYC > 0) ? WD_W'(TIMEOUT_CYC - 1) : '0;
    localparam logic [GID_W-1:0] LAST_CLIENT = GID_W'(NUM_CLIENTS - 1);

    arb_state_t                    state_q;
    arb_state_t                    state_d;
    logic [GID_W-1:0]              grant_q;
    logic [WD_W-1:0]               wd_q;
    logic                          timed_out_q;
    logic [NUM_CLIENTS*DATA_W-1:0] data_q;
    logic                          pick_valid;
    logic [GID_W-1:0]              pick_winner;
    logic [NUM_CLIENTS-1:0]        grant_onehot;
    logic                          wd_expired;

    rr_priority_picker #(
        .NUM_CLIENTS (NUM_CLIENTS),
        .GID_W       (GID_W)
    ) u_picker (
        .request    (bus.start_request),
        .last_grant (grant_q),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign grant_onehot = NUM_CLIENTS'(1) << grant_q;

    // A finish arriving in the expiry cycle takes precedence over the timeout.
    assign wd_expired = (TIMEOUT_CYC > 0) && (wd_q == WD_LIMIT) && !bus.target_state_machine_finished;

    always_comb begin
        state_d                        = state_q;
        bus.start_target_state_machine = 1'b0;
        bus.reset_start_request        = '0;
        bus.finish                     = '0;
        bus.timeout_error              = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = GIVE_START;
                end
            end
            GIVE_START: begin
                bus.start_target_state_machine = 1'b1;
                bus.reset_start_request        = grant_onehot;
                state_d                        = WAIT_FINISH;
            end
            WAIT_FINISH: begin
                if (bus.target_state_machine_finished) begin
                    state_d = REGISTER_DATA;
                end else if (wd_expired) begin
                    state_d = GIVE_FINISH;
                end
            end
            REGISTER_DATA: begin
                state_d = GIVE_FINISH;
            end
            GIVE_FINISH: begin
                bus.finish        = grant_onehot;
                bus.timeout_error = timed_out_q ? grant_onehot : '0;
                state_d           = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge sm_clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= LAST_CLIENT;
            wd_q        <= '0;
            timed_out_q <= 1'b0;
            data_q      <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && pick_valid) begin
                grant_q <= pick_winner;
            end
            if (state_q == GIVE_START) begin
                wd_q <= '0;
            end else if (state_q == WAIT_FINISH) begin
                wd_q <= wd_q + WD_W'(1);
            end
            if (state_q == WAIT_FINISH) begin
                timed_out_q <= wd_expired;
            end else if (state_q == GIVE_FINISH) begin
                timed_out_q <= 1'b0;
            end
            if (state_q == REGISTER_DATA) begin
                for (int i = 0; i < NUM_CLIENTS; i++) begin
                    if (grant_q == GID_W'(i)) begin
                        data_q[i*DATA_W +: DATA_W] <= bus.in_received_data;
                    end
                end
            end
        end
    end

    always_comb begin
        bus.output_arguments = '0;
        for (int i = 0; i < NUM_CLIENTS; i++) begin
            if (grant_q == GID_W'(i)) begin
                bus.output_arguments = bus.input_arguments[i*ARG_W +: ARG_W];
            end
        end
    end

    assign bus.received_data = data_q;
    assign bus.grant_id      = grant_q;
    assign bus.busy          = (state_q != IDLE);

endmodule

// File: tb/tb_multi_client_sm_arbiter.sv
// Bench for multi_client_sm_arbiter: a 4-client instance with a 5-cycle watchdog and a 2-client narrow instance,
// both compared cycle by cycle against a round-robin reference model.
module tb_multi_client_sm_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 8;
    localparam int TO  = 5;
    localparam int N2  = 2;
    localparam int AW2 = 16;
    localparam int DW2 = 4;

    logic sm_clk;
    logic reset;
    int   checks;
    int   errors;

    logic [N-1:0]   pend;
    logic [AW-1:0]  args [N];
    logic [DW-1:0]  model_data [N];
    logic           fin;
    logic [DW-1:0]  rdata;
    int             last_grant;

    logic [N2-1:0]  pend2;
    logic [AW2-1:0] args2 [N2];
    logic [DW2-1:0] model_data2 [N2];
    logic           fin2;
    logic [DW2-1:0] rdata2;
    int             last_grant2;

    multi_client_sm_arbiter_if #(.NUM_CLIENTS(N), .ARG_W(AW), .DATA_W(DW)) bus ();
    multi_client_sm_arbiter_if #(.NUM_CLIENTS(N2), .ARG_W(AW2), .DATA_W(DW2)) bus2 ();

    multi_client_sm_arbiter #(
        .NUM_CLIENTS (N), .ARG_W (AW), .DATA_W (DW), .TIMEOUT_CYC (TO)
    ) dut (
        .sm_clk (sm_clk), .reset (reset), .bus (bus)
    );

    multi_client_sm_arbiter #(
        .NUM_CLIENTS (N2), .ARG_W (AW2), .DATA_W (DW2), .TIMEOUT_CYC (0)
    ) dut_small (
        .sm_clk (sm_clk), .reset (reset), .bus (bus2)
    );

    initial sm_clk = 1'b0;
    always #5 sm_clk = ~sm_clk;

    assign bus.start_request                  = pend;
    assign bus.target_state_machine_finished  = fin;
    assign bus.in_received_data               = rdata;
    assign bus2.start_request                 = pend2;
    assign bus2.target_state_machine_finished = fin2;
    assign bus2.in_received_data              = rdata2;

    always_comb begin
        bus.input_arguments = '0;
        for (int i = 0; i < N; i++) bus.input_arguments[i*AW +: AW] = args[i];
    end

    always_comb begin
        bus2.input_arguments = '0;
        for (int i = 0; i < N2; i++) bus2.input_arguments[i*AW2 +: AW2] = args2[i];
    end

    initial begin
        #100000;
        $display("[TB] FAIL global_time_limit observed=expired required=finished");
        $fatal(1, "[TB] time limit reached");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Scan upward from last+1 with wrap; first pending requester wins.
    function automatic int model_winner(input logic [N-1:0] req, input int last);
        for (int k = 1; k <= N; k++) begin
            if (req[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N*DW-1:0] model_packed();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = model_data[i];
        return r;
    endfunction

    function automatic logic [N2*DW2-1:0] model_packed2();
        logic [N2*DW2-1:0] r;
        for (int i = 0; i < N2; i++) r[i*DW2 +: DW2] = model_data2[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) model_data[i] = '0;
        for (int i = 0; i < N2; i++) model_data2[i] = '0;
        last_grant  = N - 1;
        last_grant2 = N2 - 1;
    endtask

    // One full transaction on the 4-client DUT; fin_cycle < 0 means the target never answers.
    task automatic apply_stimulus(input logic [N-1:0] new_req, input int fin_cycle,
                                  input logic [DW-1:0] result, input bit pre_fin);
        int          win;
        logic [N-1:0] oh;
        pend = pend | new_req;
        win  = model_winner(pend, last_grant);
        oh   = '0;
        oh[win] = 1'b1;
        fin   = pre_fin;
        rdata = DW'($urandom);
        #1;
        check("idle_busy", 64'(bus.busy), 64'(0));
        check("idle_start", 64'(bus.start_target_state_machine), 64'(0));
        @(negedge sm_clk);
        rdata = DW'($urandom);
        #1;
        check("start_pulse", 64'(bus.start_target_state_machine), 64'(1));
        check("reset_req", 64'(bus.reset_start_request), 64'(oh));
        check("grant_id", 64'(bus.grant_id), 64'(win));
        check("out_args", 64'(bus.output_arguments), 64'(args[win]));
        check("busy_start", 64'(bus.busy), 64'(1));
        pend[win]  = 1'b0;
        last_grant = win;
        for (int w = 0; w < TO; w++) begin
            @(negedge sm_clk);
            fin   = (w == fin_cycle);
            rdata = DW'($urandom);
            #1;
            check("wait_quiet", 64'({bus.start_target_state_machine, bus.finish, bus.reset_start_request}), 64'(0));
            if (w == fin_cycle) break;
        end
        if (fin_cycle >= 0) begin
            @(negedge sm_clk);
            fin   = 1'b0;
            rdata = result;
            #1;
            check("reg_no_finish", 64'(bus.finish), 64'(0));
            model_data[win] = result;
            @(negedge sm_clk);
            rdata = DW'($urandom);
            #1;
            check("finish", 64'(bus.finish), 64'(oh));
            check("no_timeout", 64'(bus.timeout_error), 64'(0));
        end else begin
            @(negedge sm_clk);
            #1;
            check("finish_to", 64'(bus.finish), 64'(oh));
            check("timeout_err", 64'(bus.timeout_error), 64'(oh));
        end
        check("data", 64'(bus.received_data), 64'(model_packed()));
        @(negedge sm_clk);
        #1;
        check("back_idle", 64'({bus.busy, bus.finish, bus.timeout_error}), 64'(0));
        check("data_idle", 64'(bus.received_data), 64'(model_packed()));
    endtask

    // Both narrow clients request continuously; grants must alternate.
    task automatic check_output(input logic [DW2-1:0] result);
        int            win;
        logic [N2-1:0] oh;
        pend2 = 2'b11;
        win   = (last_grant2 + 1) % N2;
        oh    = '0;
        oh[win] = 1'b1;
        #1;
        check("s_idle", 64'(bus2.busy), 64'(0));
        @(negedge sm_clk);
        #1;
        check("s_start", 64'(bus2.start_target_state_machine), 64'(1));
        check("s_grant", 64'(bus2.grant_id), 64'(win));
        check("s_args", 64'(bus2.output_arguments), 64'(args2[win]));
        last_grant2 = win;
        @(negedge sm_clk);
        fin2 = 1'b1;
        #1;
        check("s_wait", 64'(bus2.finish), 64'(0));
        @(negedge sm_clk);
        fin2   = 1'b0;
        rdata2 = result;
        #1;
        model_data2[win] = result;
        @(negedge sm_clk);
        rdata2 = DW2'($urandom);
        #1;
        check("s_finish", 64'(bus2.finish), 64'(oh));
        check("s_data", 64'(bus2.received_data), 64'(model_packed2()));
        check("s_no_x", 64'({$isunknown(bus2.finish), $isunknown(bus2.received_data),
                              $isunknown(bus2.output_arguments), $isunknown(bus2.grant_id),
                              $isunknown(bus2.timeout_error), $isunknown(bus2.busy)}), 64'(0));
        @(negedge sm_clk);
        #1;
        check("s_back_idle", 64'(bus2.busy), 64'(0));
    endtask

    initial begin
        logic [N-1:0] rq;
        int           fc;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        pend   = '0;
        fin    = 1'b0;
        rdata  = '0;
        pend2  = '0;
        fin2   = 1'b0;
        rdata2 = '0;
        for (int i = 0; i < N; i++) args[i] = $urandom;
        for (int i = 0; i < N2; i++) args2[i] = AW2'($urandom);
        model_reset();
        $display("[TB] reset");
        @(negedge sm_clk);
        @(negedge sm_clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_grant", 64'(bus.grant_id), 64'(last_grant));
        check("rst_data", 64'(bus.received_data), 64'(model_packed()));
        check("rst_pulses", 64'({bus.start_target_state_machine, bus.finish,
                                  bus.reset_start_request, bus.timeout_error}), 64'(0));
        check("rst_small_no_x", 64'({$isunknown(bus2.received_data), $isunknown(bus2.grant_id),
                                      $isunknown(bus2.finish), $isunknown(bus2.busy)}), 64'(0));
        @(negedge sm_clk);
        reset = 1'b0;

        $display("[TB] single client 2");
        args[2] = 32'hDEAD_BEEF;
        apply_stimulus(4'b0100, 0, 8'h5A, 1'b0);

        $display("[TB] round robin 0,1,3");
        for (int i = 0; i < 6; i++) apply_stimulus(4'b1011, 1, DW'($urandom), 1'b0);

        $display("[TB] watchdog");
        apply_stimulus(4'b0010, 2, 8'hC3, 1'b0);
        apply_stimulus(4'b0010, -1, 8'h00, 1'b0);
        apply_stimulus(4'b0010, TO - 1, 8'h3C, 1'b0);

        $display("[TB] finished high during GIVE_START");
        apply_stimulus(4'b1000, 2, 8'hA7, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 14; i++) begin
            for (int c = 0; c < N; c++) args[c] = $urandom;
            rq = N'($urandom_range(1, 15));
            fc = $urandom_range(0, TO);
            if (fc == TO) fc = -1;
            apply_stimulus(rq, fc, DW'($urandom), 1'($urandom_range(0, 1)) && (fc > 0));
        end

        $display("[TB] reset during WAIT_FINISH");
        pend = 4'b1000;
        @(negedge sm_clk);
        pend = '0;
        @(negedge sm_clk);
        @(negedge sm_clk);
        #1;
        check("pre_rst_busy", 64'(bus.busy), 64'(1));
        check("pre_rst_grant", 64'(bus.grant_id), 64'(3));
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_busy", 64'(bus.busy), 64'(0));
        check("async_data", 64'(bus.received_data), 64'(model_packed()));
        check("async_grant", 64'(bus.grant_id), 64'(last_grant));
        check("async_finish", 64'(bus.finish), 64'(0));
        @(negedge sm_clk);
        #1;
        check("rst_hold_finish", 64'(bus.finish), 64'(0));
        reset = 1'b0;
        apply_stimulus(4'b1111, 0, DW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) apply_stimulus(4'b0000, 1, DW'($urandom), 1'b0);

        $display("[TB] two-client instance");
        for (int i = 0; i < 4; i++) begin
            args2[0] = AW2'($urandom);
            args2[1] = AW2'($urandom);
            check_output(DW2'($urandom));
        end
        pend2 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
